// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Owns the program counter and the IF/ID pipeline register. The PC drives a
//   combinational instruction memory; the returned word is captured together
//   with PC+4 into the IF/ID register that decode consumes. Handles hazard
//   freeze, branch redirect with flush, and a sticky halt on out-of-range fetch.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   freeze        hazard stall from decode: hold PC and IF/ID register
//   branch_taken  redirect request from execute (beats freeze)
//   branch_addr   redirect target, low two bits ignored
//   imem_addr     word-aligned fetch address (the PC) to instruction memory
//   imem_instr    instruction memory read data, same cycle as imem_addr
//   if_pc         PC+4 of the instruction held in IF/ID
//   if_instr      instruction held in IF/ID, 0 (nop) for a bubble
//   if_valid      if_instr is a real fetched instruction
//   fetch_oob     sticky flag: a fetch beyond MEMORY_SIZE words was attempted
//   fetch_count   number of instructions delivered with if_valid=1 (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                     WORD_LEN    = 32,
  parameter int                     ADDRESS_LEN = 32,
  parameter int                     MEMORY_SIZE = 2048,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic [WORD_LEN-1:0]    imem_instr,
  output logic [ADDRESS_LEN-1:0] if_pc,
  output logic [WORD_LEN-1:0]    if_instr,
  output logic                   if_valid,
  output logic                   fetch_oob,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [ADDRESS_LEN-1:0] MEM_WORDS = ADDRESS_LEN'(MEMORY_SIZE);

  state_t                 state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [ADDRESS_LEN-1:0] if_pc_q, if_pc_d;
  logic [WORD_LEN-1:0]    if_instr_q, if_instr_d;
  logic                   if_valid_q, if_valid_d;
  logic                   fetch_oob_q, fetch_oob_d;
  logic [31:0]            fetch_count_q, fetch_count_d;

  logic [ADDRESS_LEN-1:0] pc_plus4;
  logic [ADDRESS_LEN-1:0] pc_index;
  logic                   in_range;

  // PC+4 wraps naturally at the address width; the range check is done on
  // the already-wrapped PC held in pc_q.
  assign pc_plus4 = pc_q + ADDRESS_LEN'(4);
  assign pc_index = {2'b00, pc_q[ADDRESS_LEN-1:2]};
  assign in_range = (pc_index < MEM_WORDS);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    fetch_oob_d   = fetch_oob_q;
    fetch_count_d = fetch_count_q;

    if (branch_taken) begin
      // Redirect flushes the word fetched this cycle; one bubble results.
      pc_d       = branch_addr & ~ADDRESS_LEN'(3);
      if_pc_d    = '0;
      if_instr_d = '0;
      if_valid_d = 1'b0;
      state_d    = RUN;
    end else if (state_q == BOOT) begin
      // Single bubble after reset release; freeze has no effect here.
      if_valid_d = 1'b0;
      state_d    = RUN;
    end else if (freeze) begin
      // Hold everything.
    end else if (state_q == RUN) begin
      if (in_range) begin
        if_instr_d    = imem_instr;
        if_pc_d       = pc_plus4;
        if_valid_d    = 1'b1;
        pc_d          = pc_plus4;
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        if_instr_d  = '0;
        if_valid_d  = 1'b0;
        fetch_oob_d = 1'b1;
        state_d     = HALT;
      end
    end else begin
      // HALT: park on the offending PC until a branch or reset.
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      if_valid_q    <= 1'b0;
      fetch_oob_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      fetch_oob_q   <= fetch_oob_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign fetch_oob   = fetch_oob_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit. Three instances cover the
//   default configuration, a 16-word memory and a near-top reset PC. Each
//   instance sees its own combinational instruction memory model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory image: words 1 and 2 are two MOV instructions, word 0 is 0, the
  // rest carry their index so each fetch is identifiable.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx == 32'd0)      return 32'h0000_0000;
    else if (idx == 32'd1) return 32'hE3A0_0014;
    else if (idx == 32'd2) return 32'hE3A0_1A01;
    else                   return 32'hA500_0000 | idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- default instance ----------------
  logic        a_rst_n = 1'b0, a_freeze = 1'b0, a_br = 1'b0;
  logic [31:0] a_br_addr = '0;
  logic [31:0] a_addr, a_pc, a_instr, a_cnt;
  logic        a_valid, a_oob;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(a_rst_n), .freeze(a_freeze), .branch_taken(a_br),
    .branch_addr(a_br_addr), .imem_addr(a_addr), .imem_instr(mem_word(a_addr)),
    .if_pc(a_pc), .if_instr(a_instr), .if_valid(a_valid), .fetch_oob(a_oob),
    .fetch_count(a_cnt)
  );

  // ---------------- 16-word memory instance ----------------
  logic        s_rst_n = 1'b0, s_freeze = 1'b0, s_br = 1'b0;
  logic [31:0] s_br_addr = '0;
  logic [31:0] s_addr, s_pc, s_instr, s_cnt;
  logic        s_valid, s_oob;

  instruction_fetch_unit #(.MEMORY_SIZE(16)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .freeze(s_freeze), .branch_taken(s_br),
    .branch_addr(s_br_addr), .imem_addr(s_addr), .imem_instr(mem_word(s_addr)),
    .if_pc(s_pc), .if_instr(s_instr), .if_valid(s_valid), .fetch_oob(s_oob),
    .fetch_count(s_cnt)
  );

  // ---------------- high reset PC instance ----------------
  logic        h_rst_n = 1'b0, h_freeze = 1'b0, h_br = 1'b0;
  logic [31:0] h_br_addr = '0;
  logic [31:0] h_addr, h_pc, h_instr, h_cnt;
  logic        h_valid, h_oob;

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_high (
    .clk(clk), .rst_n(h_rst_n), .freeze(h_freeze), .branch_taken(h_br),
    .branch_addr(h_br_addr), .imem_addr(h_addr), .imem_instr(mem_word(h_addr)),
    .if_pc(h_pc), .if_instr(h_instr), .if_valid(h_valid), .fetch_oob(h_oob),
    .fetch_count(h_cnt)
  );

  // Boot bubble then three deliveries of words 0..2.
  task automatic boot_seq(input string tag);
    tick();
    chk({tag, "_boot_valid"}, {31'd0, a_valid}, 32'd0);
    chk({tag, "_boot_addr"}, a_addr, 32'h0);
    tick();
    chk({tag, "_e2_pc"}, a_pc, 32'h4);
    chk({tag, "_e2_instr"}, a_instr, 32'h0);
    chk({tag, "_e2_valid"}, {31'd0, a_valid}, 32'd1);
    chk({tag, "_e2_cnt"}, a_cnt, 32'd1);
    tick();
    chk({tag, "_e3_pc"}, a_pc, 32'h8);
    chk({tag, "_e3_instr"}, a_instr, 32'hE3A0_0014);
    chk({tag, "_e3_cnt"}, a_cnt, 32'd2);
    tick();
    chk({tag, "_e4_pc"}, a_pc, 32'hC);
    chk({tag, "_e4_instr"}, a_instr, 32'hE3A0_1A01);
    chk({tag, "_e4_cnt"}, a_cnt, 32'd3);
    chk({tag, "_e4_addr"}, a_addr, 32'hC);
  endtask

  initial begin
    // T1: reset state and first fetches
    tick(); tick();
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_oob", {31'd0, a_oob}, 32'd0);
    chk("rst_cnt", a_cnt, 32'd0);
    a_rst_n = 1'b1;
    boot_seq("t1");

    // T2: freeze holds PC and IF/ID
    a_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_addr", a_addr, 32'hC);
      chk("t2_pc", a_pc, 32'hC);
      chk("t2_valid", {31'd0, a_valid}, 32'd1);
      chk("t2_cnt", a_cnt, 32'd3);
    end
    a_freeze = 1'b0;
    tick();
    chk("t2_rel_instr", a_instr, 32'hA500_0003);
    chk("t2_rel_pc", a_pc, 32'h10);
    chk("t2_rel_cnt", a_cnt, 32'd4);

    // T3: branch beats freeze, low bits dropped, one bubble
    a_br = 1'b1; a_br_addr = 32'h66; a_freeze = 1'b1;
    tick();
    a_br = 1'b0; a_freeze = 1'b0;
    chk("t3_addr", a_addr, 32'h64);
    chk("t3_valid", {31'd0, a_valid}, 32'd0);
    chk("t3_instr", a_instr, 32'h0);
    chk("t3_cnt", a_cnt, 32'd4);
    tick();
    chk("t3_instr2", a_instr, 32'hA500_0019);
    chk("t3_pc2", a_pc, 32'h68);
    chk("t3_cnt2", a_cnt, 32'd5);

    // T5: asynchronous reset mid-run at PC 0x20
    a_br = 1'b1; a_br_addr = 32'h20;
    tick();
    a_br = 1'b0;
    tick();
    chk("t5_pre_addr", a_addr, 32'h24);
    chk("t5_pre_instr", a_instr, 32'hA500_0008);
    #2 a_rst_n = 1'b0;
    #1;
    chk("t5_addr", a_addr, 32'h0);
    chk("t5_pc", a_pc, 32'h0);
    chk("t5_instr", a_instr, 32'h0);
    chk("t5_valid", {31'd0, a_valid}, 32'd0);
    chk("t5_cnt", a_cnt, 32'd0);
    tick();
    a_rst_n = 1'b1;
    boot_seq("t5");

    // T4: 16-word memory, run off the end, halt, branch recovery
    s_rst_n = 1'b1;
    tick();
    chk("t4_boot_valid", {31'd0, s_valid}, 32'd0);
    for (int i = 0; i < 16; i++) tick();
    chk("t4_last_instr", s_instr, 32'hA500_000F);
    chk("t4_last_pc", s_pc, 32'h40);
    chk("t4_last_cnt", s_cnt, 32'd16);
    chk("t4_last_oob", {31'd0, s_oob}, 32'd0);
    tick();
    chk("t4_oob", {31'd0, s_oob}, 32'd1);
    chk("t4_oob_valid", {31'd0, s_valid}, 32'd0);
    chk("t4_oob_instr", s_instr, 32'h0);
    chk("t4_oob_addr", s_addr, 32'h40);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_halt_valid", {31'd0, s_valid}, 32'd0);
      chk("t4_halt_addr", s_addr, 32'h40);
      chk("t4_halt_cnt", s_cnt, 32'd16);
    end
    s_br = 1'b1; s_br_addr = 32'h0;
    tick();
    s_br = 1'b0;
    chk("t4_br_addr", s_addr, 32'h0);
    chk("t4_br_oob", {31'd0, s_oob}, 32'd1);
    tick();
    chk("t4_res_valid", {31'd0, s_valid}, 32'd1);
    chk("t4_res_pc", s_pc, 32'h4);
    chk("t4_res_cnt", s_cnt, 32'd17);
    tick();
    chk("t4_res_instr", s_instr, 32'hE3A0_0014);
    chk("t4_res_oob", {31'd0, s_oob}, 32'd1);

    // T6: reset PC at top of address space is out of range
    chk("t6_rst_addr", h_addr, 32'hFFFF_FFFC);
    h_rst_n = 1'b1;
    tick();
    chk("t6_boot_addr", h_addr, 32'hFFFF_FFFC);
    chk("t6_boot_oob", {31'd0, h_oob}, 32'd0);
    tick();
    chk("t6_oob", {31'd0, h_oob}, 32'd1);
    chk("t6_valid", {31'd0, h_valid}, 32'd0);
    chk("t6_addr", h_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_halt_addr", h_addr, 32'hFFFF_FFFC);
    h_br = 1'b1; h_br_addr = 32'h3;
    tick();
    h_br = 1'b0;
    chk("t6_br_addr", h_addr, 32'h0);
    tick();
    chk("t6_res_valid", {31'd0, h_valid}, 32'd1);
    chk("t6_res_pc", h_pc, 32'h4);
    chk("t6_res_cnt", h_cnt, 32'd1);
    chk("t6_res_oob", {31'd0, h_oob}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
